// File: rtl/decode_imm_stage.sv
// Decode-side stage: classifies the RV32 immediate format, builds the extended
// immediate and presents it through a registered 2-entry skid buffer.
module decode_imm_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_instr,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_instr,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [2:0]           out_imm_type,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] stall_count
);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_imm_stage supports only XLEN=32");
  end

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_C    = 3'd6
  } imm_type_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_t   imm_type;
    logic        illegal;
  } entry_t;

  // Major opcode is instr[6:2]; the length bits [1:0] only drive out_illegal.
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  imm_type_t              dec_type;
  logic      [31:0]       dec_imm;
  entry_t                 new_entry;
  entry_t                 main_q, main_d, skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [CNT_WIDTH-1:0]   stall_q;
  logic                   accept, consume;

  always_comb begin
    dec_type = IMM_NONE;
    case (in_instr[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: dec_type = IMM_I;
      OPC_STORE:                      dec_type = IMM_S;
      OPC_BRANCH:                     dec_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             dec_type = IMM_U;
      OPC_JAL:                        dec_type = IMM_J;
      OPC_SYSTEM:                     dec_type = in_instr[14] ? IMM_C : IMM_NONE;
      default:                        dec_type = IMM_NONE;
    endcase
  end

  always_comb begin
    dec_imm = 32'd0;
    case (dec_type)
      IMM_I: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S: dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B: dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U: dec_imm = {in_instr[31:12], 12'd0};
      IMM_J: dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      IMM_C: dec_imm = {27'd0, in_instr[19:15]};
      default: dec_imm = 32'd0;
    endcase
  end

  always_comb begin
    new_entry.instr    = in_instr;
    new_entry.pc       = in_pc;
    new_entry.imm      = dec_imm;
    new_entry.imm_type = dec_type;
    new_entry.illegal  = (in_instr[1:0] != 2'b11);
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign consume  = main_valid_q && out_ready;

  // Skid is only ever full while main is full, so an empty main never needs to look past it.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        if (accept) main_d = new_entry;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid    = main_valid_q;
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: vector table, hand-written buffer/flush/reset
// sequences and random traffic against a FIFO-level reference model.
module tb_decode_imm_stage;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_C    = 3'd6;
  localparam int STALL_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  decode_imm_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal),
    .stall_count(stall_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  exp_t q[$];
  int   mStall = 0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[15];

  // Immediate computed as a signed offset with plain arithmetic.
  function automatic exp_t refModel(logic [31:0] instr, logic [31:0] pc);
    exp_t e;
    int   v;
    e.instr = instr;
    e.pc    = pc;
    e.ill   = (instr[1:0] != 2'b11);
    e.typ   = T_NONE;
    v = 0;
    case (instr[6:2])
      5'b00000, 5'b00100, 5'b11001: begin
        e.typ = T_I;
        v = (instr[31] ? -2048 : 0) + int'(instr[30:20]);
      end
      5'b01000: begin
        e.typ = T_S;
        v = (instr[31] ? -2048 : 0) + int'(instr[30:25]) * 32 + int'(instr[11:7]);
      end
      5'b11000: begin
        e.typ = T_B;
        v = (instr[31] ? -4096 : 0) + int'(instr[7]) * 2048 + int'(instr[30:25]) * 32
            + int'(instr[11:8]) * 2;
      end
      5'b01101, 5'b00101: begin
        e.typ = T_U;
        v = int'(instr & 32'hFFFFF000);
      end
      5'b11011: begin
        e.typ = T_J;
        v = (instr[31] ? -1048576 : 0) + int'(instr[19:12]) * 4096
            + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
      end
      5'b11100: begin
        if (instr[14]) begin
          e.typ = T_C;
          v = int'(instr[19:15]);
        end
      end
      default: v = 0;
    endcase
    e.imm = 32'(v);
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [4:0]  ops[11] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01101,
                             5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b01100, 5'b00011};
    logic [31:0] w;
    w = $urandom;
    w[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
    return w;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag);
    cmp({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    cmp({tag, ":in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    cmp({tag, ":stall_count"}, 32'(stall_count), 32'(mStall));
    if (q.size() > 0) begin
      cmp({tag, ":out_instr"}, out_instr, q[0].instr);
      cmp({tag, ":out_pc"}, out_pc, q[0].pc);
      cmp({tag, ":out_imm"}, out_imm, q[0].imm);
      cmp({tag, ":out_imm_type"}, 32'(out_imm_type), 32'(q[0].typ));
      cmp({tag, ":out_illegal"}, 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // Model advance at the edge: a 2-deep FIFO whose ready is "not full".
  task automatic modelEdge(logic v, logic [31:0] instr, logic [31:0] pc, logic rdy, logic fl);
    bit acc, con;
    acc = v && (q.size() < 2);
    con = (q.size() > 0) && rdy;
    if ((q.size() > 0) && !rdy && (mStall < STALL_MAX)) mStall++;
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(refModel(instr, pc));
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] instr, logic [31:0] pc,
                               logic rdy, logic fl, string tag);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    modelEdge(v, instr, pc, rdy, fl);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    tbl[0]  = '{32'hFFF00093, T_I,    32'hFFFFFFFF, 1'b0};
    tbl[1]  = '{32'hFE112E23, T_S,    32'hFFFFFFFC, 1'b0};
    tbl[2]  = '{32'h123452B7, T_U,    32'h12345000, 1'b0};
    tbl[3]  = '{32'h300FD073, T_C,    32'h0000001F, 1'b0};
    tbl[4]  = '{32'h30009073, T_NONE, 32'h00000000, 1'b0};
    tbl[5]  = '{32'hFE000CE3, T_B,    32'hFFFFFFF8, 1'b0};
    tbl[6]  = '{32'h801FF0EF, T_J,    32'hFFFFF800, 1'b0};
    tbl[7]  = '{32'h7FF08067, T_I,    32'h000007FF, 1'b0};
    tbl[8]  = '{32'h80002083, T_I,    32'hFFFFF800, 1'b0};
    tbl[9]  = '{32'hFFFFF117, T_U,    32'hFFFFF000, 1'b0};
    tbl[10] = '{32'h12345678, T_NONE, 32'h00000000, 1'b1};
    tbl[11] = '{32'h002081B3, T_NONE, 32'h00000000, 1'b0};
    tbl[12] = '{32'h00000073, T_NONE, 32'h00000000, 1'b0};
    tbl[13] = '{32'h0020A423, T_S,    32'h00000008, 1'b0};
    tbl[14] = '{32'h00208463, T_B,    32'h00000008, 1'b0};

    // Reset state, checked while reset is still asserted.
    #3;
    cmp("rst:out_valid", 32'(out_valid), 32'd0);
    cmp("rst:in_ready", 32'(in_ready), 32'd1);
    cmp("rst:stall_count", 32'(stall_count), 32'd0);
    cmp("rst:out_instr", out_instr, 32'd0);
    cmp("rst:out_pc", out_pc, 32'd0);
    cmp("rst:out_imm", out_imm, 32'd0);
    cmp("rst:out_imm_type", 32'(out_imm_type), 32'(T_NONE));
    cmp("rst:out_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, back-to-back with downstream always ready.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, tbl[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, "table");
      cmp($sformatf("tbl%0d:imm", i), out_imm, tbl[i].imm);
      cmp($sformatf("tbl%0d:type", i), 32'(out_imm_type), 32'(tbl[i].typ));
      cmp($sformatf("tbl%0d:illegal", i), 32'(out_illegal), 32'(tbl[i].ill));
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "drain0");

    // Three stalled cycles while a second instruction lands in the skid entry.
    applyStimulus(1'b1, 32'hFFF00093, 32'h2000, 1'b1, 1'b0, "stallA");
    applyStimulus(1'b1, 32'hFE112E23, 32'h2004, 1'b0, 1'b0, "stallB");
    cmp("stall:in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'h123452B7, 32'h2008, 1'b0, 1'b0, "stall2");
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "stall3");
    cmp("stall:count3", 32'(stall_count), 32'd3);
    cmp("stall:held_pc", out_pc, 32'h2000);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "drain1");
    cmp("drain:second_pc", out_pc, 32'h2004);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "drain2");

    // Flush with both entries full and an offer pending.
    applyStimulus(1'b1, 32'h00208463, 32'h3000, 1'b0, 1'b0, "fillA");
    applyStimulus(1'b1, 32'h0020A423, 32'h3004, 1'b0, 1'b0, "fillB");
    applyStimulus(1'b1, 32'h801FF0EF, 32'h3008, 1'b0, 1'b1, "flush");
    cmp("flush:out_valid", 32'(out_valid), 32'd0);
    cmp("flush:in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "postflush");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), randInstr(), $urandom,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), "random");
    end

    // Asynchronous reset between edges with a stalled entry in flight.
    applyStimulus(1'b1, 32'hFFF00093, 32'h4000, 1'b0, 1'b0, "preRst");
    in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h4004; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    modelEdge(1'b1, 32'h0020A423, 32'h4004, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst:out_valid", 32'(out_valid), 32'd0);
    cmp("arst:stall_count", 32'(stall_count), 32'd0);
    cmp("arst:in_ready", 32'(in_ready), 32'd1);
    cmp("arst:out_imm", out_imm, 32'd0);
    q.delete();
    mStall = 0;
    @(negedge clk);
    checkOutput("inRst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randInstr(), 32'h5000 + 32'(i * 4), 1'b1, 1'b0, "resume");

    // Long stall to hit saturation and confirm no wrap.
    applyStimulus(1'b1, 32'h300FD073, 32'h6000, 1'b0, 1'b0, "satLoad");
    for (int i = 0; i < 65541; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, "sat");
    cmp("sat:all_ones", 32'(stall_count), 32'h0000FFFF);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "satRelease");
    cmp("sat:retained", 32'(stall_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
